// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths and exponent bias.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int FP_W   = 1 + EXP_W + FRAC_W;
endpackage

// File: rtl/leading_zero_count.sv
// Leading-zero count of a W-bit word; an all-zero word reports W.
module leading_zero_count #(
  parameter int W = 32
) (
  input  logic [W-1:0]         data,
  output logic [$clog2(W):0]   cnt
);
  localparam int LZ_W = $clog2(W) + 1;

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    cnt = LZ_W'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) cnt = LZ_W'(W - 1 - i);
    end
  end
endmodule

// File: rtl/int_to_fp_pipe.sv
// Three-stage integer to FP32 converter with valid/ready flow control.
// Define INT_TO_FP_ROUND_EN for round-to-nearest-even; otherwise truncates.
module int_to_fp_pipe
  import fp_pkg::*;
#(
  parameter int IN_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_data,
  output logic            out_inexact
);
  localparam int LZ_W  = $clog2(IN_W) + 1;
  localparam int LOW_W = IN_W - 1 + FRAC_W + 1;

  logic vld_p1_q, vld_p2_q, vld_p3_q;
  logic vld_p1_d, vld_p2_d, vld_p3_d;
  logic ld_p1, ld_p2, ld_p3;

  logic                   sign_p1_q, sign_p1_d;
  logic [IN_W-1:0]        mag_p1_q, mag_p1_d;
  logic                   sign_p2_q, sign_p2_d;
  logic                   zero_p2_q, zero_p2_d;
  logic [EXP_W-1:0]       exp_p2_q, exp_p2_d;
  logic [IN_W-2:0]        norm_p2_q, norm_p2_d;
  logic [FP_W-1:0]        res_p3_q, res_p3_d;
  logic                   inx_p3_q, inx_p3_d;

  logic                   sign_new;
  logic signed [IN_W-1:0] neg_s;
  logic [LZ_W-1:0]        lz;
  logic [IN_W-1:0]        norm_full;
  logic [FP_W:0]          packed_res;

  // Bits below the leading one: 23 fraction bits, then guard, then sticky.
  function automatic logic [FP_W:0] round_pack(
    input logic             sgn,
    input logic             zero,
    input logic [EXP_W-1:0] e,
    input logic [IN_W-2:0]  norm
  );
    logic [LOW_W-1:0]  low;
    logic [FRAC_W-1:0] frac;
    logic              guard, sticky, up;
    logic [FRAC_W:0]   sum;
    logic [EXP_W-1:0]  e_r;
    low    = {norm, {(FRAC_W + 1){1'b0}}};
    frac   = low[LOW_W-1 -: FRAC_W];
    guard  = low[LOW_W-FRAC_W-1];
    sticky = |low[LOW_W-FRAC_W-2:0];
`ifdef INT_TO_FP_ROUND_EN
    up = guard & (sticky | frac[0]);
`else
    up = 1'b0;
`endif
    // A carry out leaves the fraction bits all zero and bumps the exponent.
    sum = {1'b0, frac} + {{FRAC_W{1'b0}}, up};
    e_r = e + EXP_W'(sum[FRAC_W]);
    if (zero) return '0;
    return {guard | sticky, sgn, e_r, sum[FRAC_W-1:0]};
  endfunction

  always_comb begin
    ld_p3    = !vld_p3_q || out_ready;
    ld_p2    = !vld_p2_q || ld_p3;
    ld_p1    = !vld_p1_q || ld_p2;
    in_ready = rst_n && ld_p1;
    vld_p1_d = ld_p1 ? (in_valid && in_ready) : vld_p1_q;
    vld_p2_d = ld_p2 ? vld_p1_q : vld_p2_q;
    vld_p3_d = ld_p3 ? vld_p2_q : vld_p3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  // ---- stage 1: sign / magnitude ----
  always_comb begin
    sign_new  = in_signed && in_data[IN_W-1];
    neg_s     = -$signed(in_data);
    sign_p1_d = ld_p1 ? sign_new : sign_p1_q;
    mag_p1_d  = ld_p1 ? (sign_new ? $unsigned(neg_s) : in_data) : mag_p1_q;
  end

  // ---- stage 2: leading-zero count and normalise ----
  leading_zero_count #(.W(IN_W)) u_lzc (
    .data (mag_p1_q),
    .cnt  (lz)
  );

  always_comb begin
    norm_full = mag_p1_q << lz;
    sign_p2_d = ld_p2 ? sign_p1_q : sign_p2_q;
    zero_p2_d = ld_p2 ? !norm_full[IN_W-1] : zero_p2_q;
    exp_p2_d  = ld_p2 ? EXP_W'(BIAS + IN_W - 1 - int'(lz)) : exp_p2_q;
    norm_p2_d = ld_p2 ? norm_full[IN_W-2:0] : norm_p2_q;
  end

  // ---- stage 3: round and pack ----
  always_comb begin
    packed_res = round_pack(sign_p2_q, zero_p2_q, exp_p2_q, norm_p2_q);
    res_p3_d   = ld_p3 ? packed_res[FP_W-1:0] : res_p3_q;
    inx_p3_d   = ld_p3 ? packed_res[FP_W] : inx_p3_q;
  end

  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    mag_p1_q  <= mag_p1_d;
    sign_p2_q <= sign_p2_d;
    zero_p2_q <= zero_p2_d;
    exp_p2_q  <= exp_p2_d;
    norm_p2_q <= norm_p2_d;
    res_p3_q  <= res_p3_d;
    inx_p3_q  <= inx_p3_d;
  end

  // Data registers carry no reset; outputs are forced to zero when idle.
  assign out_valid   = vld_p3_q;
  assign out_data    = vld_p3_q ? res_p3_q : '0;
  assign out_inexact = vld_p3_q && inx_p3_q;
endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Randomized and directed bench for int_to_fp_pipe (IN_W=32) against a value-level model.
module tb_int_to_fp_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_inexact;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;
  int nout  = 0;
  bit bp_mode = 0;
  logic [32:0] sb[$];
  logic        held_v = 1'b0;
  logic [32:0] held_d;

  always #5 clk = ~clk;

  int_to_fp_pipe #(.IN_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Value-level conversion: magnitude, exponent from floor(log2), quotient and remainder.
  function automatic logic [32:0] ref_cvt(input logic [31:0] d, input logic s);
    longint unsigned m, q, r;
    int e, sh;
    logic neg, inx;
    neg = s & d[31];
    m = neg ? (64'h1_0000_0000 - {32'h0, d}) : {32'h0, d};
    if (m == 0) return 33'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e); r = 0; sh = 0;
    end else begin
      sh = e - 23; q = m >> sh; r = m - (q << sh);
    end
    inx = (r != 0);
`ifdef INT_TO_FP_ROUND_EN
    begin : rnd
      longint unsigned half;
      half = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
      if (r != 0 && (r > half || (r == half && q[0]))) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    end
`endif
    return {inx, neg, 8'(e + 127), q[22:0]};
  endfunction

  // Scoreboard: push on accepted input, pop and compare on delivered output.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) chk("hold_stable", {out_inexact, out_data}, held_d);
      held_v = out_valid && !out_ready;
      held_d = {out_inexact, out_data};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else chk("result", {out_inexact, out_data}, sb.pop_front());
        nout++;
      end
      if (in_valid && in_ready) sb.push_back(ref_cvt(in_data, in_signed));
    end
  end

  task automatic send(input logic [31:0] d, input logic s);
    int n;
    logic acc;
    in_data = d; in_signed = s; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (bp_mode) out_ready = ($urandom % 3) != 0;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic run_one(input string tag, input logic [31:0] d, input logic s,
                         input logic [31:0] want_d, input logic want_i);
    int n;
    out_ready = 1'b1;
    send(d, s);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_data"}, out_data, want_d);
    chk({tag, "_inx"}, out_inexact, want_i);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_inx", out_inexact, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run_one("one_s",  32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0);
    run_one("m1_s",   32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0);
    run_one("min_s",  32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0);
    run_one("min_u",  32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0);
    run_one("zero_s", 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0);
    run_one("zero_u", 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
`ifdef INT_TO_FP_ROUND_EN
    run_one("max_u",  32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1);
    run_one("tie_dn", 32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1);
    run_one("tie_up", 32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1);
`else
    run_one("max_u",  32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF, 1'b1);
    run_one("tie_dn", 32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1);
    run_one("tie_up", 32'h0100_0003, 1'b0, 32'h4B80_0001, 1'b1);
`endif
    drain();

    // Burst of 8 with a 5-cycle downstream stall in the middle.
    n0 = nout;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom, 1'($urandom));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("burst_count", nout - n0, 8);

    // Random operands with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      case ($urandom % 4)
        0: d = d >> ($urandom % 32);
        1: d = (32'h1 << ($urandom % 32)) + 32'($urandom % 3) - 32'd1;
        2: d = d & 32'h0000_01FF;
        default: ;
      endcase
      send(d, 1'($urandom));
    end
    bp_mode = 0;
    out_ready = 1'b1;
    drain();

    // Reset with three operations in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, 1'($urandom));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      chk("no_stale", out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    n0 = nout;
    run_one("post_rst", 32'hFFFF_FFFE, 1'b1, 32'hC000_0000, 1'b0);
    drain();
    chk("post_rst_count", nout - n0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
